// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32I core control path: opcodes and the
// pipeline-control FSM state encoding.
package rv32_pkg;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } ctrl_state;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of ID/EX observation inputs and stage-register control outputs
// exchanged between the core datapath and hazard_ctrl.
interface hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [6:0]  id_opcode;
  logic        id_nop;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic        ex_we_reg;
  logic        branch_taken;
  logic        we_pc;
  logic        we_if_id;
  logic        nop_if_id;
  logic        we_id_ex;
  logic        nop_id_ex;
  logic        nop_ex_mem;
  logic        halted;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_opcode, id_nop,
           ex_rd, ex_is_load, ex_we_reg, branch_taken,
    input  we_pc, we_if_id, nop_if_id, we_id_ex, nop_id_ex, nop_ex_mem,
           halted, stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_opcode, id_nop,
           ex_rd, ex_is_load, ex_we_reg, branch_taken,
    output we_pc, we_if_id, nop_if_id, we_id_ex, nop_id_ex, nop_ex_mem,
           halted, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl_load_use.sv
// Combinational load-use compare: a load in EX whose destination is read by
// the (non-bubble) instruction in ID.
module load_use_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       id_nop,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       ex_we_reg,
  output logic       stall_req
);
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit   = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit   = id_use_rs2 && (id_rs2 == ex_rd);
  // x0 is never a real dependency, so a load to x0 never stalls.
  assign stall_req = ex_is_load && ex_we_reg && (ex_rd != 5'd0) &&
                     (rs1_hit || rs2_hit) && !id_nop;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline control FSM: boot bubbles, load-use stall, branch flush, SYSTEM
// drain/halt, plus stall and flush performance counters.
module hazard_ctrl #(
  parameter int BOOT_CYCLES  = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);
  import rv32_pkg::*;

  localparam int MAX_CYC = (BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  ctrl_state        state;
  ctrl_state        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [31:0]      stall_count;
  logic [31:0]      flush_count;
  logic             stall_req;
  logic             stall_inc;
  logic             flush_inc;
  logic             we_pc;
  logic             we_if_id;
  logic             nop_if_id;
  logic             we_id_ex;
  logic             nop_id_ex;
  logic             nop_ex_mem;
  logic             halted;

  load_use_detect u_load_use (
    .id_rs1     (hz.id_rs1),
    .id_rs2     (hz.id_rs2),
    .id_use_rs1 (hz.id_use_rs1),
    .id_use_rs2 (hz.id_use_rs2),
    .id_nop     (hz.id_nop),
    .ex_rd      (hz.ex_rd),
    .ex_is_load (hz.ex_is_load),
    .ex_we_reg  (hz.ex_we_reg),
    .stall_req  (stall_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      cnt         <= CNT_W'(BOOT_CYCLES - 1);
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall_inc) stall_count <= stall_count + 32'd1;
      if (flush_inc) flush_count <= flush_count + 32'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    we_pc      = 1'b1;
    we_if_id   = 1'b1;
    nop_if_id  = 1'b0;
    we_id_ex   = 1'b1;
    nop_id_ex  = 1'b0;
    nop_ex_mem = 1'b0;
    halted     = 1'b0;
    // Reset shows the boot bubble pattern immediately, before the first edge.
    if (rst || state == BOOT) begin
      we_pc      = 1'b0;
      nop_if_id  = 1'b1;
      nop_id_ex  = 1'b1;
      nop_ex_mem = 1'b1;
      cnt_nxt    = cnt - CNT_W'(1);
      if (cnt == '0) begin
        state_nxt = RUN;
        cnt_nxt   = cnt;
      end
    end else begin
      case (state)
        RUN: begin
          if (hz.branch_taken) begin
            nop_if_id = 1'b1;
            nop_id_ex = 1'b1;
            flush_inc = 1'b1;
          end else if (stall_req) begin
            we_pc     = 1'b0;
            we_if_id  = 1'b0;
            nop_id_ex = 1'b1;
            stall_inc = 1'b1;
          end else if (hz.id_opcode == OPC_SYSTEM && !hz.id_nop) begin
            we_pc     = 1'b0;
            we_if_id  = 1'b0;
            nop_id_ex = 1'b1;
            state_nxt = DRAIN;
            cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          we_pc     = 1'b0;
          we_if_id  = 1'b0;
          nop_id_ex = 1'b1;
          cnt_nxt   = cnt - CNT_W'(1);
          if (cnt == '0) begin
            state_nxt = HALTED;
            cnt_nxt   = cnt;
          end
        end
        default: begin
          halted    = 1'b1;
          we_pc     = 1'b0;
          we_if_id  = 1'b0;
          nop_id_ex = 1'b1;
        end
      endcase
    end
  end

  assign hz.we_pc       = we_pc;
  assign hz.we_if_id    = we_if_id;
  assign hz.nop_if_id   = nop_if_id;
  assign hz.we_id_ex    = we_id_ex;
  assign hz.nop_id_ex   = nop_id_ex;
  assign hz.nop_ex_mem  = nop_ex_mem;
  assign hz.halted      = halted;
  assign hz.stall_count = stall_count;
  assign hz.flush_count = flush_count;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with BOOT_CYCLES=2, DRAIN_CYCLES=3.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   errors = 0;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_SYS = 7'b1110011;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.BOOT_CYCLES(2), .DRAIN_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.id_rs1 = 5'd1; hz.id_rs2 = 5'd2; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
    hz.id_opcode = OPC_OP; hz.id_nop = 1'b0; hz.ex_rd = 5'd0;
    hz.ex_is_load = 1'b0; hz.ex_we_reg = 1'b0; hz.branch_taken = 1'b0;
  endtask

  task automatic set_load_use();
    hz.ex_is_load = 1'b1; hz.ex_we_reg = 1'b1; hz.ex_rd = 5'd5;
    hz.id_rs2 = 5'd5; hz.id_use_rs2 = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    #1;
    tests++; if ({hz.we_pc, hz.we_if_id, hz.nop_if_id, hz.we_id_ex, hz.nop_id_ex, hz.nop_ex_mem, hz.halted} !== 7'b0111110) begin
      errors++; $display("FAIL reset_outputs got %b want 0111110", {hz.we_pc, hz.we_if_id, hz.nop_if_id, hz.we_id_ex, hz.nop_id_ex, hz.nop_ex_mem, hz.halted}); end
    repeat (3) tick();
    tests++; if (hz.stall_count !== 32'd0 || hz.flush_count !== 32'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", hz.stall_count, hz.flush_count); end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests++; if (hz.we_pc !== 1'b0 || hz.nop_ex_mem !== 1'b1) begin
        errors++; $display("FAIL boot_cycle%0d we_pc=%b nop_ex_mem=%b want 0/1", i, hz.we_pc, hz.nop_ex_mem); end
      tick();
    end
    tests++; if ({hz.we_pc, hz.nop_if_id, hz.nop_id_ex, hz.nop_ex_mem} !== 4'b1000) begin
      errors++; $display("FAIL boot_run got %b want 1000", {hz.we_pc, hz.nop_if_id, hz.nop_id_ex, hz.nop_ex_mem}); end
  endtask

  task automatic test_load_use();
    set_load_use();
    #1;
    tests++; if ({hz.we_pc, hz.we_if_id, hz.nop_if_id, hz.nop_id_ex} !== 4'b0001) begin
      errors++; $display("FAIL load_use_ctrl got %b want 0001", {hz.we_pc, hz.we_if_id, hz.nop_if_id, hz.nop_id_ex}); end
    tick();
    idle();
    #1;
    tests++; if (hz.stall_count !== 32'd1 || hz.we_pc !== 1'b1) begin
      errors++; $display("FAIL load_use_count stall=%0d we_pc=%b want 1/1", hz.stall_count, hz.we_pc); end
  endtask

  task automatic test_no_stall();
    hz.ex_is_load = 1'b1; hz.ex_we_reg = 1'b1; hz.ex_rd = 5'd0; hz.id_rs2 = 5'd0; hz.id_use_rs2 = 1'b1;
    #1;
    tests++; if (hz.we_pc !== 1'b1 || hz.nop_id_ex !== 1'b0) begin
      errors++; $display("FAIL no_stall_x0 we_pc=%b nop_id_ex=%b want 1/0", hz.we_pc, hz.nop_id_ex); end
    tick();
    idle();
    hz.ex_is_load = 1'b1; hz.ex_we_reg = 1'b1; hz.ex_rd = 5'd7; hz.id_rs1 = 5'd7; hz.id_use_rs1 = 1'b0;
    #1;
    tests++; if (hz.we_pc !== 1'b1 || hz.we_if_id !== 1'b1) begin
      errors++; $display("FAIL no_stall_unused we_pc=%b we_if_id=%b want 1/1", hz.we_pc, hz.we_if_id); end
    tick();
    idle();
    set_load_use(); hz.id_nop = 1'b1;
    #1;
    tests++; if (hz.we_pc !== 1'b1) begin
      errors++; $display("FAIL no_stall_bubble we_pc=%b want 1", hz.we_pc); end
    tick();
    idle();
    #1;
    tests++; if (hz.stall_count !== 32'd1) begin
      errors++; $display("FAIL no_stall_count got %0d want 1", hz.stall_count); end
  endtask

  task automatic test_flush_vs_stall();
    set_load_use(); hz.branch_taken = 1'b1;
    #1;
    tests++; if ({hz.we_pc, hz.we_if_id, hz.nop_if_id, hz.nop_id_ex} !== 4'b1111) begin
      errors++; $display("FAIL flush_ctrl got %b want 1111", {hz.we_pc, hz.we_if_id, hz.nop_if_id, hz.nop_id_ex}); end
    tick();
    idle();
    #1;
    tests++; if (hz.flush_count !== 32'd1 || hz.stall_count !== 32'd1) begin
      errors++; $display("FAIL flush_counts flush=%0d stall=%0d want 1/1", hz.flush_count, hz.stall_count); end
  endtask

  task automatic test_system_vs_flush();
    hz.id_opcode = OPC_SYS; hz.branch_taken = 1'b1;
    #1;
    tests++; if ({hz.we_pc, hz.nop_if_id, hz.nop_id_ex} !== 3'b111) begin
      errors++; $display("FAIL sys_flush_ctrl got %b want 111", {hz.we_pc, hz.nop_if_id, hz.nop_id_ex}); end
    tick();
    idle();
    #1;
    tests++; if (hz.we_pc !== 1'b1 || hz.nop_ex_mem !== 1'b0 || hz.flush_count !== 32'd2) begin
      errors++; $display("FAIL sys_flush_run we_pc=%b nop_ex_mem=%b flush=%0d want 1/0/2", hz.we_pc, hz.nop_ex_mem, hz.flush_count); end
  endtask

  task automatic test_halt();
    set_load_use(); hz.id_opcode = OPC_SYS;
    #1;
    tests++; if ({hz.we_pc, hz.we_if_id, hz.nop_id_ex} !== 3'b001) begin
      errors++; $display("FAIL stall_sys_ctrl got %b want 001", {hz.we_pc, hz.we_if_id, hz.nop_id_ex}); end
    tick();
    hz.ex_is_load = 1'b0;
    #1;
    tests++; if ({hz.we_pc, hz.we_if_id, hz.nop_id_ex} !== 3'b001 || hz.stall_count !== 32'd2) begin
      errors++; $display("FAIL halt_detect ctrl=%b stall=%0d want 001/2", {hz.we_pc, hz.we_if_id, hz.nop_id_ex}, hz.stall_count); end
    tick();
    idle();
    hz.branch_taken = 1'b1;
    #1;
    tests++; if ({hz.we_pc, hz.we_if_id, hz.nop_if_id, hz.we_id_ex, hz.nop_id_ex, hz.nop_ex_mem, hz.halted} !== 7'b0001100) begin
      errors++; $display("FAIL drain_ctrl got %b want 0001100", {hz.we_pc, hz.we_if_id, hz.nop_if_id, hz.we_id_ex, hz.nop_id_ex, hz.nop_ex_mem, hz.halted}); end
    tick();
    tick();
    tests++; if (hz.halted !== 1'b0 || hz.we_pc !== 1'b0) begin
      errors++; $display("FAIL drain_early halted=%b we_pc=%b want 0/0", hz.halted, hz.we_pc); end
    tick();
    tests++; if ({hz.halted, hz.we_pc, hz.we_if_id, hz.we_id_ex, hz.nop_id_ex} !== 5'b10011) begin
      errors++; $display("FAIL halted_ctrl got %b want 10011", {hz.halted, hz.we_pc, hz.we_if_id, hz.we_id_ex, hz.nop_id_ex}); end
    set_load_use();
    repeat (3) tick();
    tests++; if (hz.halted !== 1'b1 || hz.we_pc !== 1'b0 || hz.flush_count !== 32'd2 || hz.stall_count !== 32'd2) begin
      errors++; $display("FAIL halted_hold halted=%b we_pc=%b flush=%0d stall=%0d want 1/0/2/2", hz.halted, hz.we_pc, hz.flush_count, hz.stall_count); end
  endtask

  task automatic test_reset_mid_drain();
    idle();
    rst = 1'b1; tick(); rst = 1'b0;
    tests++; if (hz.halted !== 1'b0 || hz.stall_count !== 32'd0 || hz.flush_count !== 32'd0) begin
      errors++; $display("FAIL rst_from_halt halted=%b stall=%0d flush=%0d want 0/0/0", hz.halted, hz.stall_count, hz.flush_count); end
    tick(); tick();
    hz.branch_taken = 1'b1; tick(); hz.branch_taken = 1'b0;
    hz.id_opcode = OPC_SYS; tick();
    idle(); tick();
    rst = 1'b1;
    #1;
    tests++; if ({hz.we_pc, hz.nop_if_id, hz.nop_ex_mem, hz.halted} !== 4'b0110 || hz.flush_count !== 32'd1) begin
      errors++; $display("FAIL rst_drain_ctrl got %b flush=%0d want 0110/1", {hz.we_pc, hz.nop_if_id, hz.nop_ex_mem, hz.halted}, hz.flush_count); end
    tick();
    rst = 1'b0;
    #1;
    tests++; if (hz.flush_count !== 32'd0 || hz.we_pc !== 1'b0 || hz.nop_ex_mem !== 1'b1) begin
      errors++; $display("FAIL rst_drain_boot flush=%0d we_pc=%b nop_ex_mem=%b want 0/0/1", hz.flush_count, hz.we_pc, hz.nop_ex_mem); end
    tick(); tick();
    tests++; if (hz.we_pc !== 1'b1 || hz.halted !== 1'b0 || hz.nop_ex_mem !== 1'b0) begin
      errors++; $display("FAIL rst_drain_fetch we_pc=%b halted=%b nop_ex_mem=%b want 1/0/0", hz.we_pc, hz.halted, hz.nop_ex_mem); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_flush_vs_stall();
    test_system_vs_flush();
    test_halt();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control unit that generates the write-enable (stall) and nop (bubble/flush) controls for the PC and the IF_ID, ID_EX and EX_MEM stage registers of the 5-stage RV32I core. It detects load-use hazards, flushes wrong-path instructions after a taken branch or jump resolved in EX, and injects bubbles after reset. On a SYSTEM instruction (ECALL/EBREAK) it drains the pipeline and halts the core. It also keeps stall and flush performance counters.

## Interface
Parameters:
- BOOT_CYCLES, 2: bubble cycles after reset release; legal range ≥1.
- DRAIN_CYCLES, 3: cycles from halt detection to halted; legal range ≥1.

Ports:
- clk  in  1  core clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  decoder flags: ID instruction reads rs1/rs2.
- id_opcode  in  7  opcode in ID.
- id_nop  in  1  nop_out of IF_ID; the ID slot holds a bubble.
- ex_rd  in  5  rd_out of ID_EX.
- ex_is_load, ex_we_reg  in  1 each  is_load_out and we_reg_out of ID_EX.
- branch_taken  in  1  the EX-stage branch or jump redirects the PC this cycle.
- we_pc  out  1  PC register enable.
- we_if_id, nop_if_id  out  1 each  we and nop inputs of IF_ID.
- we_id_ex, nop_id_ex  out  1 each  we and nop inputs of ID_EX.
- nop_ex_mem  out  1  nop input of EX_MEM.
- halted  out  1  core halted; remains high until rst.
- stall_count, flush_count  out  32 each  performance counters.

## Operation
- FSM states: BOOT, RUN, DRAIN, HALTED. rst forces BOOT, loads cnt = BOOT_CYCLES-1, and clears both counters.
- Outputs are combinational from the state and the current inputs. The state, cnt and the counters are registered.
- BOOT:
  - Outputs: we_pc=0, we_if_id=1, nop_if_id=1, we_id_ex=1, nop_id_ex=1, nop_ex_mem=1.
  - cnt decrements each cycle. When cnt==0, the next state is RUN.
  - These same output values hold while rst is high.
- RUN, default outputs: we_pc=1, we_if_id=1, we_id_ex=1, all nop outputs=0.
- RUN conditions are evaluated in the following priority order:
  1. Flush, when branch_taken=1:
     - nop_if_id=1, nop_id_ex=1, we_pc=1 (the PC loads the target).
     - flush_count increments.
  2. Load-use stall, when ex_is_load & ex_we_reg & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)) & !id_nop:
     - we_pc=0, we_if_id=0, nop_id_ex=1.
     - stall_count increments.
     - Lasts exactly one cycle, because the bubble then clears ex_is_load.
  3. Halt, when id_opcode==OPC_SYSTEM & !id_nop:
     - we_pc=0, we_if_id=0, nop_id_ex=1 (the SYSTEM instruction is squashed).
     - Next state DRAIN, with cnt = DRAIN_CYCLES-1.
- DRAIN:
  - Outputs: we_pc=0, we_if_id=0, we_id_ex=1, nop_id_ex=1, nop_ex_mem=0. Older instructions complete.
  - branch_taken is ignored.
  - cnt decrements. When cnt==0, the next state is HALTED.
- HALTED:
  - Outputs: halted=1, we_pc=0, we_if_id=0, we_id_ex=1, nop_id_ex=1.
  - All inputs are ignored. Only rst exits this state.
- Counters:
  - 32-bit, unsigned, wrap from 0xFFFFFFFF to 0.
  - Counting happens only in RUN.
  - Each counter increments at most once per cycle.

## Timing
- Stall and flush controls are combinational and take effect at the next clk edge. There is no added latency.
- Simultaneous branch_taken and load-use: the flush wins. The stalled ID instruction is wrong-path and is discarded. stall_count does not increment.
- Simultaneous branch_taken and a SYSTEM instruction in ID: the flush wins and the FSM stays in RUN.
- A SYSTEM instruction that load-use depends on: the stall wins. Halt is detected on the following cycle.
- halted rises DRAIN_CYCLES+1 cycles after the detection edge.
- rst in any state returns the FSM to BOOT on the next edge. Reset mid-DRAIN or in HALTED clears halted and both counters.
- Output reset values: we_pc=0, we_if_id=1, nop_if_id=1, we_id_ex=1, nop_id_ex=1, nop_ex_mem=1, halted=0, stall_count=0, flush_count=0.
- After rst deasserts, the first fetch (we_pc=1) happens in the cycle after the BOOT_CYCLES-th clock edge.

## Structure
- Shared package rv32_pkg holds OPC_SYSTEM=7'b1110011 and the ctrl_state enum {BOOT, RUN, DRAIN, HALTED}.
- One sub-module, load_use_detect: combinational hazard compare that outputs a single stall request.
- The FSM, cnt (width $clog2(max(BOOT_CYCLES,DRAIN_CYCLES))+1) and the counters live in hazard_ctrl.

## Test plan
- Reset, BOOT_CYCLES=2: hold rst 3 cycles, then release -> nop_ex_mem=1 and we_pc=0 for 2 cycles; RUN in cycle 3; counters=0.
- Load-use: ex_is_load=1, ex_we_reg=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle with we_pc=0, we_if_id=0, nop_id_ex=1; stall_count=1.
- ex_rd=0 load, and a load whose rd matches id_rs1 with id_use_rs1=0 -> no stall; stall_count unchanged.
- branch_taken=1 together with a load-use hazard -> nop_if_id=1, nop_id_ex=1, we_pc=1; flush_count=1, stall_count=0.
- ECALL in ID (id_opcode=0x73, id_nop=0), DRAIN_CYCLES=3 -> SYSTEM instruction squashed; halted=1 after 4 edges; branch_taken pulses during DRAIN are ignored; we_pc remains 0.
- rst asserted mid-DRAIN -> BOOT on the next edge; halted=0; counters cleared; normal fetch after BOOT.
